vec_trace_monitor: RTL and testbench
====================================

Name: vec_trace_monitor

Overview:
- Synthesizable successor to the MLP-policy bench monitor, for FPGA builds where no simulator console is attached.
- Watches the vector ALU result bus and the tohost port.
- Captures every matching ALU result into a FIFO and serialises it lane by lane over a valid/ready stream, which feeds the UART TX path.
- Ends the run on an exit code or a cycle timeout, drains the FIFO, then raises done with the cause.

Parameters:
- LANES, 2: number of vector ALU output lanes.
- DATA_W, 32: width of each lane (float32 bits).
- FUNC_W, 4: width of the ALU function code.
- MATCH_FUNC, 1: function code that triggers a capture.
- DEPTH, 16: FIFO depth in entries; one entry holds all lanes. Must be a power of two, at least 2.
- TOHOST_W, 8: width of the tohost port.
- EXIT_CODE, 8'h01: tohost value that ends the run.
- TIMEOUT_CYCLES, 8000: run limit in cycles; 0 disables the timeout.

Ports:
- clock  in  1  single clock for the whole block.
- reset_n  in  1  asynchronous, active-low reset.
- valu_func  in  FUNC_W  ALU function code for the current cycle.
- valu_out  in  LANES*DATA_W  ALU results; lane i occupies bits [i*DATA_W +: DATA_W].
- tohost  in  TOHOST_W  host status port.
- trace_valid  out  1  stream valid.
- trace_ready  in  1  stream ready.
- trace_data  out  DATA_W  current lane value.
- trace_lane  out  max(1,clog2(LANES))  index of the current lane.
- trace_last  out  1  high on the beat carrying lane LANES-1.
- drop_count  out  16  entries lost because the FIFO was full; saturates at 16'hFFFF.
- done  out  1  run finished and FIFO fully drained.
- exited  out  1  cause flag: run ended by EXIT_CODE.
- timed_out  out  1  cause flag: run ended by timeout.

Behaviour:
- Reset values: all outputs 0, FIFO empty, lane index 0, cycle counter 0, state RUN. Reset is asynchronous and takes effect immediately, including mid-drain; any in-flight beat is discarded.
- State machine, RUN -> DRAIN -> DONE:
  - RUN: capture is enabled; the cycle counter increments each cycle.
  - RUN -> DRAIN when tohost==EXIT_CODE (set exited), or when the counter reaches TIMEOUT_CYCLES-1 with TIMEOUT_CYCLES!=0 (set timed_out).
  - If both conditions hold in the same cycle, exit wins: only exited is set.
  - Cause flags are sticky until reset.
  - DRAIN: no captures; the serialiser keeps draining.
  - DRAIN -> DONE when the FIFO is empty and no beat is in flight.
  - DONE: done=1 and held; all inputs are ignored.
- Capture:
  - A sample is taken on a rising edge when state==RUN and valu_func==MATCH_FUNC.
  - The cycle that triggers the RUN->DRAIN transition still captures.
  - The entry is written if count<DEPTH, or if count==DEPTH and the serialiser pops an entry in the same cycle.
  - Otherwise the entry is dropped and drop_count increments (saturating).
- Serialiser:
  - Holds the head entry; trace_valid=1 whenever an entry is present.
  - A beat transfers when trace_valid && trace_ready. Each transfer advances trace_lane.
  - After the transfer on lane LANES-1, the entry is popped and trace_lane returns to 0.
  - While trace_valid=1 and trace_ready=0, trace_data, trace_lane and trace_last stay stable.
  - trace_data and trace_lane are registered (or driven from registered state), with no combinational path from trace_ready.
- Latency and throughput:
  - A sample captured at edge k gives trace_valid=1 after edge k+1 when the FIFO was empty.
  - Sustained throughput is one lane per cycle; back-to-back entries need no bubble.
- LANES==1: trace_lane is constant 0 and trace_last=1 on every beat.
- Pointer arithmetic is modulo DEPTH. The count is clog2(DEPTH)+1 bits so that full and empty are distinct.

Test Plan:
1. Basic capture:
   - Stimulus: after reset, valu_func=1 for one cycle with lanes 0x3F800000 and 0x40000000; trace_ready=1.
   - Response: beats (lane 0, 0x3F800000, last=0) then (lane 1, 0x40000000, last=1); trace_valid rises the cycle after capture.
2. Backpressure and overflow:
   - Stimulus: trace_ready=0; 20 consecutive matching cycles.
   - Response: 16 entries stored, drop_count=4. Then trace_ready=1 yields 32 beats in order, with outputs stable while stalled.
3. Exit with drain:
   - Stimulus: 3 entries queued; tohost=0x01.
   - Response: state DRAIN, exited=1. Later matching samples are ignored. done=1 only after the 6th beat transfers.
4. Timeout:
   - Stimulus: TIMEOUT_CYCLES=100; no exit.
   - Response: timed_out=1 on the 100th cycle after reset release; done=1 once the FIFO is empty; exited=0.
5. Simultaneous events:
   - Stimulus: tohost=0x01 on the timeout cycle together with a matching valu_func.
   - Response: exited=1, timed_out=0, and that cycle's sample is captured and streamed.
6. Reset mid-drain:
   - Stimulus: assert reset_n=0 asynchronously while trace_valid=1.
   - Response: all outputs 0 immediately. After release, normal capture resumes with drop_count=0.

Source files
------------

// File: rtl/vec_trace_monitor.sv
// vec_trace_monitor: on-chip replacement for the bench console monitor.
// It captures matching vector ALU results into a FIFO and streams them out
// lane by lane over a valid/ready port that feeds the UART TX path. It ends
// the run on an exit code or a cycle timeout, drains the FIFO, and then
// raises done together with the cause.
//
// Handshake: a beat transfers on a rising edge where trace_valid && trace_ready.
// trace_valid never depends on trace_ready. While a beat is stalled
// (valid=1, ready=0), trace_data, trace_lane and trace_last hold their values.
`timescale 1ns/1ps
module vec_trace_monitor #(
  parameter int unsigned          LANES          = 2,
  parameter int unsigned          DATA_W         = 32,
  parameter int unsigned          FUNC_W         = 4,
  parameter logic [FUNC_W-1:0]    MATCH_FUNC     = 4'd1,
  parameter int unsigned          DEPTH          = 16,
  parameter int unsigned          TOHOST_W       = 8,
  parameter logic [TOHOST_W-1:0]  EXIT_CODE      = 8'h01,
  parameter int unsigned          TIMEOUT_CYCLES = 8000,
  localparam int unsigned         LANE_W         = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [FUNC_W-1:0]         valu_func,
  input  logic [LANES*DATA_W-1:0]   valu_out,
  input  logic [TOHOST_W-1:0]       tohost,
  output logic                      trace_valid,
  input  logic                      trace_ready,
  output logic [DATA_W-1:0]         trace_data,
  output logic [LANE_W-1:0]         trace_lane,
  output logic                      trace_last,
  output logic [15:0]               drop_count,
  output logic                      done,
  output logic                      exited,
  output logic                      timed_out,
  output logic [1:0]                state_dbg
);

  localparam int unsigned         PTR_W     = $clog2(DEPTH);
  localparam int unsigned         CNT_W     = PTR_W + 1;
  localparam logic [LANE_W-1:0]   LAST_LANE = LANE_W'(LANES - 1);
  localparam logic [CNT_W-1:0]    FULL_CNT  = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Run control
  state_e                    state_q;
  logic [31:0]               cycle_q;
  logic                      exited_q;
  logic                      timed_out_q;
  logic                      done_q;

  // Capture stage: one register between the ALU bus and the FIFO
  logic                      stg_valid_q;
  logic [LANES*DATA_W-1:0]   stg_data_q;

  // FIFO storage and bookkeeping
  logic [DATA_W-1:0]         mem_q [DEPTH][LANES];
  logic [PTR_W-1:0]          wr_ptr_q;
  logic [PTR_W-1:0]          rd_ptr_q;
  logic [CNT_W-1:0]          count_q;

  // Serialiser and drop statistics
  logic [LANE_W-1:0]         lane_q;
  logic [15:0]               drop_q;

  // Decoded per-cycle events
  logic                      head_valid;
  logic                      lane_last;
  logic                      beat_xfer;
  logic                      pop;
  logic                      push;
  logic                      drop;
  logic                      capture_en;
  logic                      exit_hit;
  logic                      timeout_hit;

  // Decode handshake, FIFO and run-control events from registered state
  always_comb begin
    head_valid  = 1'b0;
    lane_last   = 1'b0;
    beat_xfer   = 1'b0;
    pop         = 1'b0;
    push        = 1'b0;
    drop        = 1'b0;
    capture_en  = 1'b0;
    exit_hit    = 1'b0;
    timeout_hit = 1'b0;

    head_valid  = (count_q != '0);
    lane_last   = (lane_q == LAST_LANE);
    beat_xfer   = head_valid && trace_ready;
    pop         = beat_xfer && lane_last;
    // A full FIFO still accepts the staged entry when the head pops this cycle.
    push        = stg_valid_q && ((count_q < FULL_CNT) || pop);
    drop        = stg_valid_q && !push;
    capture_en  = (state_q == ST_RUN) && (valu_func == MATCH_FUNC);
    exit_hit    = (tohost == EXIT_CODE);
    timeout_hit = (TIMEOUT_CYCLES != 0) && (cycle_q == 32'(TIMEOUT_CYCLES - 1));
  end

  // Run-control FSM: RUN counts cycles until exit or timeout, DRAIN waits for
  // the FIFO and capture stage to empty, DONE holds until reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_RUN;
      cycle_q     <= '0;
      exited_q    <= 1'b0;
      timed_out_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          cycle_q <= cycle_q + 32'd1;
          // Exit has priority over a timeout in the same cycle.
          if (exit_hit) begin
            state_q  <= ST_DRAIN;
            exited_q <= 1'b1;
          end else if (timeout_hit) begin
            state_q     <= ST_DRAIN;
            timed_out_q <= 1'b1;
          end
        end
        ST_DRAIN: begin
          if (!head_valid && !stg_valid_q) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end
        end
        ST_DONE: begin
          state_q <= ST_DONE;
        end
        default: begin
          state_q <= ST_RUN;
        end
      endcase
    end
  end

  // Capture stage: sample the ALU bus while running and the function matches
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stg_valid_q <= 1'b0;
      stg_data_q  <= '0;
    end else begin
      stg_valid_q <= capture_en;
      if (capture_en) begin
        stg_data_q <= valu_out;
      end
    end
  end

  // FIFO storage: one entry holds every lane of a sample
  always_ff @(posedge clock) begin
    if (push) begin
      for (int l = 0; l < LANES; l++) begin
        mem_q[wr_ptr_q][l] <= stg_data_q[l*DATA_W +: DATA_W];
      end
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally modulo DEPTH
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Serialiser lane index: advance per transferred beat, wrap after last lane
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      lane_q <= '0;
    end else if (beat_xfer) begin
      lane_q <= lane_last ? '0 : lane_q + 1'b1;
    end
  end

  // Drop counter: count entries lost to a full FIFO, saturating
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      drop_q <= '0;
    end else if (drop && (drop_q != 16'hFFFF)) begin
      drop_q <= drop_q + 16'd1;
    end
  end

  // Stream outputs come only from registered state, never from trace_ready.
  assign trace_valid = head_valid;
  assign trace_data  = head_valid ? mem_q[rd_ptr_q][lane_q] : '0;
  assign trace_lane  = lane_q;
  assign trace_last  = head_valid && lane_last;
  assign drop_count  = drop_q;
  assign done        = done_q;
  assign exited      = exited_q;
  assign timed_out   = timed_out_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_vec_trace_monitor.sv
// Directed bench for vec_trace_monitor: capture, backpressure/overflow,
// exit drain, timeout, simultaneous exit+timeout, and reset mid-drain.
`timescale 1ns/1ps
module tb_vec_trace_monitor;

  localparam int LANES    = 2;
  localparam int DATA_W   = 32;
  localparam int FUNC_W   = 4;
  localparam int DEPTH    = 16;
  localparam int TOHOST_W = 8;
  localparam int TIMEOUT  = 100;

  localparam logic [1:0] S_RUN   = 2'd0;
  localparam logic [1:0] S_DRAIN = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  // Clock / reset
  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  logic [FUNC_W-1:0]       valu_func = '0;
  logic [LANES*DATA_W-1:0] valu_out  = '0;
  logic [TOHOST_W-1:0]     tohost    = '0;
  logic                    trace_ready = 1'b0;
  logic                    trace_valid;
  logic [DATA_W-1:0]       trace_data;
  logic [0:0]              trace_lane;
  logic                    trace_last;
  logic [15:0]             drop_count;
  logic                    done;
  logic                    exited;
  logic                    timed_out;
  logic [1:0]              state_dbg;

  vec_trace_monitor #(
    .LANES          (LANES),
    .DATA_W         (DATA_W),
    .FUNC_W         (FUNC_W),
    .MATCH_FUNC     (4'd1),
    .DEPTH          (DEPTH),
    .TOHOST_W       (TOHOST_W),
    .EXIT_CODE      (8'h01),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .valu_func   (valu_func),
    .valu_out    (valu_out),
    .tohost      (tohost),
    .trace_valid (trace_valid),
    .trace_ready (trace_ready),
    .trace_data  (trace_data),
    .trace_lane  (trace_lane),
    .trace_last  (trace_last),
    .drop_count  (drop_count),
    .done        (done),
    .exited      (exited),
    .timed_out   (timed_out),
    .state_dbg   (state_dbg)
  );

  // Scoreboard
  logic [DATA_W-1:0] exp_q[$];
  int exp_lane = 0;
  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Driver tasks; all driving and sampling happens at the falling edge
  task automatic tick;
    @(negedge clock);
  endtask

  task automatic do_reset;
    reset_n     = 1'b0;
    valu_func   = '0;
    valu_out    = '0;
    tohost      = '0;
    trace_ready = 1'b0;
    exp_q.delete();
    exp_lane = 0;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic set_sample(input logic [31:0] l0, input logic [31:0] l1, input bit expect_it);
    valu_func = 4'd1;
    valu_out  = {l1, l0};
    if (expect_it) begin
      exp_q.push_back(l0);
      exp_q.push_back(l1);
    end
  endtask

  task automatic idle;
    valu_func = 4'd0;
    valu_out  = '0;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_valid"}, 32'(trace_valid), 32'd0);
    check_eq({tag, "_data"},  trace_data,        32'd0);
    check_eq({tag, "_lane"},  32'(trace_lane),  32'd0);
    check_eq({tag, "_last"},  32'(trace_last),  32'd0);
    check_eq({tag, "_drop"},  32'(drop_count),  32'd0);
    check_eq({tag, "_done"},  32'(done),        32'd0);
    check_eq({tag, "_exit"},  32'(exited),      32'd0);
    check_eq({tag, "_tmo"},   32'(timed_out),   32'd0);
    check_eq({tag, "_state"}, 32'(state_dbg),   32'(S_RUN));
  endtask

  // Consume n_beats from the stream; stall_mod>0 drops ready every stall_mod cycles.
  // Every valid cycle, including stalled ones, is compared to the queue head.
  task automatic stream_beats(input int n_beats, input int stall_mod);
    int  got;
    int  cyc;
    logic rdy;
    got = 0;
    cyc = 0;
    while (got < n_beats && cyc < n_beats * 4 + 20) begin
      rdy = (stall_mod == 0) || ((cyc % stall_mod) != 0);
      trace_ready = rdy;
      if (trace_valid) begin
        if (exp_q.size() == 0) begin
          check_eq("unexpected_beat", 32'(trace_valid), 32'd0);
        end else begin
          check_eq("beat_data", trace_data, exp_q[0]);
          check_eq("beat_lane", 32'(trace_lane), 32'(exp_lane));
          check_eq("beat_last", 32'(trace_last), 32'(exp_lane == LANES - 1));
          if (rdy) begin
            void'(exp_q.pop_front());
            exp_lane = (exp_lane == LANES - 1) ? 0 : exp_lane + 1;
            got++;
          end
        end
      end
      tick;
      cyc++;
    end
    trace_ready = 1'b0;
    check_eq("beat_count", 32'(got), 32'(n_beats));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    reset_n = 1'b0;
    @(negedge clock);
    check_all_zero("reset");
    do_reset;

    // 1. Basic capture
    set_sample(32'h3F80_0000, 32'h4000_0000, 1'b1);
    tick;
    check_eq("t1_valid_lat0", 32'(trace_valid), 32'd0);
    idle;
    trace_ready = 1'b1;
    tick;
    check_eq("t1_valid_lat1", 32'(trace_valid), 32'd1);
    stream_beats(2, 0);
    check_eq("t1_empty", 32'(trace_valid), 32'd0);
    check_eq("t1_drop", 32'(drop_count), 32'd0);
    check_eq("t1_state", 32'(state_dbg), 32'(S_RUN));

    // 2. Backpressure and overflow
    do_reset;
    trace_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      set_sample(32'hA000_0000 + 32'(i), 32'hB000_0000 + 32'(i), (i < DEPTH));
      tick;
    end
    idle;
    tick;
    check_eq("t2_drop", 32'(drop_count), 32'd4);
    check_eq("t2_valid", 32'(trace_valid), 32'd1);
    stream_beats(32, 3);
    check_eq("t2_empty", 32'(trace_valid), 32'd0);
    check_eq("t2_no_tmo", 32'(timed_out), 32'd0);

    // 3. Exit with drain
    do_reset;
    trace_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_sample(32'hC000_0000 + 32'(i), 32'hD000_0000 + 32'(i), 1'b1);
      tick;
    end
    idle;
    tohost = 8'h01;
    tick;
    tohost = 8'h00;
    check_eq("t3_state", 32'(state_dbg), 32'(S_DRAIN));
    check_eq("t3_exited", 32'(exited), 32'd1);
    check_eq("t3_tmo", 32'(timed_out), 32'd0);
    check_eq("t3_done0", 32'(done), 32'd0);
    set_sample(32'hEEEE_0000, 32'hEEEE_0001, 1'b0);
    tick;
    tick;
    check_eq("t3_drop", 32'(drop_count), 32'd0);
    stream_beats(5, 0);
    check_eq("t3_done_b5", 32'(done), 32'd0);
    stream_beats(1, 0);
    check_eq("t3_done_b6", 32'(done), 32'd0);
    tick;
    check_eq("t3_done", 32'(done), 32'd1);
    check_eq("t3_state_done", 32'(state_dbg), 32'(S_DONE));
    tohost = 8'h01;
    trace_ready = 1'b1;
    repeat (3) tick;
    check_eq("t3_hold_done", 32'(done), 32'd1);
    check_eq("t3_hold_valid", 32'(trace_valid), 32'd0);
    check_eq("t3_hold_exit", 32'(exited), 32'd1);
    idle;

    // 4. Timeout on the 100th edge after reset release
    do_reset;
    set_sample(32'h1111_0000, 32'h2222_0000, 1'b1);
    tick;
    idle;
    for (int i = 0; i < TIMEOUT - 2; i++) tick;
    check_eq("t4_tmo_early", 32'(timed_out), 32'd0);
    check_eq("t4_state_run", 32'(state_dbg), 32'(S_RUN));
    tick;
    check_eq("t4_tmo", 32'(timed_out), 32'd1);
    check_eq("t4_exited", 32'(exited), 32'd0);
    check_eq("t4_state", 32'(state_dbg), 32'(S_DRAIN));
    check_eq("t4_done0", 32'(done), 32'd0);
    stream_beats(2, 0);
    tick;
    check_eq("t4_done", 32'(done), 32'd1);
    check_eq("t4_exited_end", 32'(exited), 32'd0);

    // 5. Exit, timeout and a matching sample in the same cycle
    do_reset;
    for (int i = 0; i < TIMEOUT - 1; i++) tick;
    tohost = 8'h01;
    set_sample(32'h5555_0000, 32'h6666_0000, 1'b1);
    tick;
    idle;
    tohost = 8'h00;
    check_eq("t5_exited", 32'(exited), 32'd1);
    check_eq("t5_tmo", 32'(timed_out), 32'd0);
    check_eq("t5_state", 32'(state_dbg), 32'(S_DRAIN));
    stream_beats(2, 0);
    tick;
    check_eq("t5_done", 32'(done), 32'd1);

    // 6. Reset mid-drain
    do_reset;
    trace_ready = 1'b0;
    for (int i = 0; i < 18; i++) begin
      set_sample(32'h7000_0000 + 32'(i), 32'h8000_0000 + 32'(i), (i < DEPTH));
      tick;
    end
    idle;
    tohost = 8'h01;
    tick;
    tohost = 8'h00;
    check_eq("t6_state", 32'(state_dbg), 32'(S_DRAIN));
    check_eq("t6_drop", 32'(drop_count), 32'd2);
    stream_beats(3, 0);
    check_eq("t6_mid_lane", 32'(trace_lane), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check_all_zero("t6_async");
    @(negedge clock);
    do_reset;
    trace_ready = 1'b1;
    set_sample(32'h9000_0001, 32'h9000_0002, 1'b1);
    tick;
    idle;
    stream_beats(2, 0);
    check_eq("t6_post_drop", 32'(drop_count), 32'd0);
    check_eq("t6_post_state", 32'(state_dbg), 32'(S_RUN));
    check_eq("t6_post_exit", 32'(exited), 32'd0);

    // Final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
